// File: rtl/rng_pkg.sv
// Shared constants, FSM state type and range-mask helper for random_reg_source.
package rng_pkg;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {IDLE, DRAW, CHECK} rng_state_t;

    // Smallest all-ones mask covering [0, range); range 1 gives 0, range 256 gives 8'hFF.
    function automatic logic [7:0] rng_mask(input int range);
        int m;
        m = (1 << $clog2(range)) - 1;
        return m[7:0];
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR that shifts every cycle; a zero state is reloaded from SEED,
// and i_xor is folded into the shift result so callers can inject entropy.
module lfsr16
    import rng_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic [15:0] i_xor,
    output logic [15:0] o_state
);

    logic [15:0] r_state;
    logic [15:0] w_shift;

    always_comb begin
        w_shift = {1'b0, r_state[15:1]} ^ (r_state[0] ? LFSR_TAPS : 16'h0000);
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset)
            r_state <= SEED;
        else if (r_state == 16'h0000)
            r_state <= SEED;
        else
            r_state <= w_shift ^ i_xor;
    end

    assign o_state = r_state;

endmodule

// File: rtl/random_reg_source.sv
// Uniform draw in [0, RANGE) by mask-and-reject over a free-running LFSR, refreshed
// periodically or on request. Define RNG_ENTROPY_EN to mix button edges into the LFSR.
module random_reg_source
    import rng_pkg::*;
#(
    parameter int          RANGE     = 9,
    parameter int          PERIOD    = 1_000_000,
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          MAX_TRIES = 8
) (
    input  logic       clock,
    input  logic       ctrl_reset,
    input  logic       entropy_in,
    input  logic       refresh_req,
    output logic [7:0] random_data,
    output logic       random_valid,
    output logic       draw_pulse
);

    localparam logic [7:0] MASK   = rng_mask(RANGE);
    localparam logic [8:0] RANGE9 = 9'(RANGE);
    localparam int         PW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int         TW     = $clog2(MAX_TRIES + 1);

    rng_state_t    r_state, w_next;
    logic [PW-1:0] r_cnt;
    logic [TW-1:0] r_tries;
    logic [7:0]    r_cand;
    logic          r_pending;
    logic [15:0]   w_lfsr;
    logic [15:0]   w_xor;
    logic [7:0]    w_lfsr_hi_unused;
    logic          w_tick, w_trig;
    logic          w_start, w_capture, w_accept;
    logic [7:0]    w_accept_val;

`ifdef RNG_ENTROPY_EN
    logic [2:0]  r_ent_sync;
    logic [15:0] r_cyc;

    // Two synchronizer flops, a third holds the previous level for edge detection.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            r_ent_sync <= 3'b000;
            r_cyc      <= 16'h0000;
        end else begin
            r_ent_sync <= {r_ent_sync[1:0], entropy_in};
            r_cyc      <= r_cyc + 16'h0001;
        end
    end

    assign w_xor = (r_ent_sync[1] & ~r_ent_sync[2]) ? r_cyc : 16'h0000;
`else
    logic w_entropy_unused;
    assign w_entropy_unused = entropy_in;
    assign w_xor            = 16'h0000;
`endif

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .i_clock (clock),
        .i_reset (ctrl_reset),
        .i_xor   (w_xor),
        .o_state (w_lfsr)
    );

    assign w_lfsr_hi_unused = w_lfsr[15:8];

    // Free-running period counter; draws never restart it.
    assign w_tick = (r_cnt == PW'(PERIOD - 1));
    assign w_trig = w_tick | refresh_req;

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset)
            r_cnt <= '0;
        else if (w_tick)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_start      = 1'b0;
        w_capture    = 1'b0;
        w_accept     = 1'b0;
        w_accept_val = r_cand;
        case (r_state)
            IDLE: begin
                if (w_trig || r_pending) begin
                    w_next  = DRAW;
                    w_start = 1'b1;
                end
            end
            DRAW: begin
                w_capture = 1'b1;
                w_next    = CHECK;
            end
            CHECK: begin
                if ({1'b0, r_cand} < RANGE9) begin
                    w_accept = 1'b1;
                    w_next   = IDLE;
                end else if (r_tries < TW'(MAX_TRIES)) begin
                    w_next = DRAW;
                end else begin
                    // cand < 2*RANGE here, so the fold-down is always in range.
                    w_accept     = 1'b1;
                    w_accept_val = r_cand - RANGE9[7:0];
                    w_next       = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            r_tries      <= '0;
            r_cand       <= 8'h00;
            r_pending    <= 1'b0;
            random_data  <= 8'h00;
            random_valid <= 1'b0;
            draw_pulse   <= 1'b0;
        end else begin
            draw_pulse <= w_accept;
            if (w_accept) begin
                random_data  <= w_accept_val;
                random_valid <= 1'b1;
            end
            if (w_start)
                r_tries <= '0;
            else if (w_capture)
                r_tries <= r_tries + 1'b1;
            if (w_capture)
                r_cand <= w_lfsr[7:0] & MASK;
            // Triggers seen while busy collapse into one deferred draw.
            if (r_state == IDLE)
                r_pending <= 1'b0;
            else if (w_trig)
                r_pending <= 1'b1;
        end
    end

endmodule

// File: tb/tb_random_reg_source.sv
// Scoreboard bench for random_reg_source over several RANGE/PERIOD/MAX_TRIES builds.
module tb_random_reg_source;

    localparam int NCFG = 5;
    localparam int RG [NCFG] = '{9, 1, 256, 129, 256};
    localparam int PR [NCFG] = '{16, 16, 16, 16, 4096};
    localparam int MT [NCFG] = '{8, 8, 8, 1, 8};
    localparam int MK [NCFG] = '{15, 0, 255, 255, 255};
    localparam int NL = 8192;

    typedef struct {
        int val;
        int acc;
    } exp_t;

    logic clock = 1'b0;
    logic ctrl_reset;
    logic entropy_in;
    logic refresh_req;

    int total = 0;
    int bad   = 0;
    logic [15:0] lt [NL];

    always #5 clock = ~clock;

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d", nm, act, req);
        end
    endtask

    // Expected draw for a trigger sampled at edge e: tries read the LFSR every other cycle.
    function automatic void predict(input int r, input int mk, input int mt, input int e,
                                     output int val, output int acc);
        int c;
        val = 0;
        acc = 0;
        for (int j = 0; j < mt; j++) begin
            c   = int'(lt[e + 2*j][7:0]) & mk;
            acc = e + 2 + 2*j;
            if (c < r) begin
                val = c;
                return;
            end
            val = c - r;
        end
    endfunction

    initial begin
        logic [15:0] s;
        lt[0] = 16'hACE1;
        for (int i = 1; i < NL; i++) begin
            s = lt[i-1];
            lt[i] = (s == 16'h0) ? 16'hACE1 : ({1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0));
        end
    end

    for (genvar g = 0; g < NCFG; g++) begin : cfg
        localparam int R = RG[g];
        localparam int P = PR[g];
        localparam int M = MT[g];

        logic [7:0] data;
        logic       valid, pulse;
        exp_t       q[$];
        int         e = 0;
        int         npulse = 0;
        int         first_e = 0;

        random_reg_source #(.RANGE(R), .PERIOD(P), .MAX_TRIES(M)) u_dut (
            .clock        (clock),
            .ctrl_reset   (ctrl_reset),
            .entropy_in   (entropy_in),
            .refresh_req  (refresh_req),
            .random_data  (data),
            .random_valid (valid),
            .draw_pulse   (pulse)
        );

        // Trigger model: pushes one expectation per draw start.
        initial begin
            int busy = 0, pend = 0, acc = 0, v = 0;
            bit trig;
            forever begin
                @(posedge clock or posedge ctrl_reset);
                if (ctrl_reset) begin
                    e = 0; busy = 0; pend = 0;
                    q.delete();
                end else begin
                    e++;
                    trig = ((e % P) == 0) || refresh_req;
                    if (!busy) begin
                        if (trig || pend) begin
                            predict(R, MK[g], M, e, v, acc);
                            q.push_back('{val: v, acc: acc});
                            busy = 1;
                            pend = 0;
                        end
                    end else begin
                        if (trig) pend = 1;
                        if (e == acc) busy = 0;
                    end
                end
            end
        end

        initial begin
            int last = 0;
            int seen = 0;
            exp_t x;
            forever begin
                @(negedge clock);
                chk($sformatf("cfg%0d_lfsr_e%0d", g, e), int'(u_dut.u_lfsr.r_state), int'(lt[e]));
                if (ctrl_reset) begin
                    chk($sformatf("cfg%0d_rst_data", g), int'(data), 0);
                    chk($sformatf("cfg%0d_rst_valid", g), int'(valid), 0);
                    chk($sformatf("cfg%0d_rst_pulse", g), int'(pulse), 0);
                    last = 0; seen = 0; npulse = 0; first_e = 0;
                end else if (pulse) begin
                    if (q.size() == 0) begin
                        chk($sformatf("cfg%0d_spurious_pulse_e%0d", g, e), 1, 0);
                    end else begin
                        x = q.pop_front();
                        chk($sformatf("cfg%0d_draw_edge", g), e, x.acc);
                        chk($sformatf("cfg%0d_draw_val_e%0d", g, e), int'(data), x.val);
                    end
                    chk($sformatf("cfg%0d_in_range", g), int'(int'(data) < R), 1);
                    chk($sformatf("cfg%0d_valid_set", g), int'(valid), 1);
                    last = int'(data);
                    seen = 1;
                    npulse++;
                    if (first_e == 0) first_e = e;
                end else begin
                    chk($sformatf("cfg%0d_hold_e%0d", g, e), int'(data), last);
                    chk($sformatf("cfg%0d_valid_e%0d", g, e), int'(valid), seen);
                    if (q.size() > 0 && q[0].acc < e) begin
                        chk($sformatf("cfg%0d_missed_draw_due%0d", g, q[0].acc), e, q[0].acc);
                        void'(q.pop_front());
                    end
                end
            end
        end
    end

    // Returns at the negedge just before edge n, so inputs set now are sampled at edge n.
    task automatic goto_edge(input int n);
        int guard;
        guard = 0;
        while (cfg[0].e < n - 1 && guard < 20000) begin
            @(negedge clock);
            guard++;
        end
    endtask

    initial begin
        ctrl_reset  = 1'b1;
        refresh_req = 1'b0;
        entropy_in  = 1'b0;
        repeat (3) @(negedge clock);
        #2 ctrl_reset = 1'b0;

        @(negedge clock);
        chk("lfsr_after_1", int'(cfg[0].u_dut.u_lfsr.r_state), 'hE270);
        @(negedge clock);
        chk("lfsr_after_2", int'(cfg[0].u_dut.u_lfsr.r_state), 'h7138);

        // Button edge must not disturb the LFSR in the default build.
        goto_edge(100); entropy_in = 1'b1;
        @(negedge clock); entropy_in = 1'b0;
        @(negedge clock); entropy_in = 1'b1;
        @(negedge clock); entropy_in = 1'b0;

        // Request in IDLE at edge 200, again during CHECK at edge 202.
        goto_edge(200); refresh_req = 1'b1;
        @(negedge clock); refresh_req = 1'b0;
        @(negedge clock); refresh_req = 1'b1;
        @(negedge clock); refresh_req = 1'b0;
        goto_edge(215);
        chk("req_during_check_pulses", cfg[4].npulse, 2);

        // Request coincident with a tick on the PERIOD=16 builds.
        goto_edge(224); refresh_req = 1'b1;
        @(negedge clock); refresh_req = 1'b0;
        goto_edge(240);
        chk("req_single_pulses", cfg[4].npulse, 3);
        chk("periodic_first_edge", cfg[2].first_e, 18);

        goto_edge(3400);
        chk("periodic_draw_count", int'(cfg[0].npulse >= 200), 1);

        // Reset while cfg4 sits in CHECK (draw started at edge 3500).
        goto_edge(3500); refresh_req = 1'b1;
        @(negedge clock); refresh_req = 1'b0;
        @(negedge clock);
        #2 ctrl_reset = 1'b1;
        #1;
        chk("midreset_data", int'(cfg[4].data), 0);
        chk("midreset_pulse", int'(cfg[4].pulse), 0);
        chk("midreset_valid", int'(cfg[4].valid), 0);
        repeat (2) @(negedge clock);
        #2 ctrl_reset = 1'b0;

        goto_edge(40);
        chk("post_reset_first_edge", cfg[2].first_e, 18);
        chk("post_reset_no_pending", cfg[4].npulse, 0);
        chk("range1_zero", int'(cfg[1].data), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
